calc_datapath: RTL and testbench

CALC_DATAPATH -- requirements
Module: calc_datapath

---
 rtl/calc_datapath.sv | 146 ++++++++++++++
 tb/tb_calc_datapath.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/calc_datapath.sv
// Calculator datapath: 4-entry register file (R0 hardwired to zero), registered read ports, ALU and output register.
// Optional carry/zero status flags are built only when CALC_DATAPATH_FLAGS_EN is defined.
module calc_datapath #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [1:0]   s1,
    input  logic [1:0]   WA,
    input  logic         WE,
    input  logic [1:0]   RAA,
    input  logic [1:0]   RAB,
    input  logic         REA,
    input  logic         REB,
    input  logic [1:0]   C,
    input  logic         S2,
    output logic [W-1:0] out,
    output logic         carry,
    output logic         zero
);

    typedef enum logic [1:0] {
        OP_XOR = 2'd0,
        OP_AND = 2'd1,
        OP_SUB = 2'd2,
        OP_ADD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_ZERO = 2'd1,
        SEL_IN2  = 2'd2,
        SEL_IN1  = 2'd3
    } sel_e;

    logic [W-1:0] r_q [1:3];
    logic [W-1:0] r_d [1:3];
    logic [W-1:0] rf_view [0:3];
    logic [W-1:0] qa_q, qa_d;
    logic [W-1:0] qb_q, qb_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] alu;
    logic [W-1:0] mux1;
    logic         wr_en;

    always_comb begin
        alu = '0;
        case (op_e'(C))
            OP_ADD: alu = qa_q + qb_q;
            OP_SUB: alu = qa_q - qb_q;
            OP_AND: alu = qa_q & qb_q;
            OP_XOR: alu = qa_q ^ qb_q;
            default: alu = '0;
        endcase
    end

    always_comb begin
        mux1 = '0;
        case (sel_e'(s1))
            SEL_IN1:  mux1 = in1;
            SEL_IN2:  mux1 = in2;
            SEL_ZERO: mux1 = '0;
            SEL_ALU:  mux1 = alu;
            default:  mux1 = '0;
        endcase
    end

    assign wr_en = WE && (WA != 2'd0);

    // Reads and the output load sample the post-write view, which gives write-first bypass.
    always_comb begin
        for (int unsigned i = 1; i < 4; i++) begin
            r_d[i] = r_q[i];
            if (wr_en && (WA == 2'(i))) begin
                r_d[i] = mux1;
            end
        end
        rf_view[0] = '0;
        for (int unsigned i = 1; i < 4; i++) begin
            rf_view[i] = r_d[i];
        end
        qa_d  = REA ? rf_view[RAA] : qa_q;
        qb_d  = REB ? rf_view[RAB] : qb_q;
        out_d = S2 ? r_d[3] : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < 4; i++) begin
                r_q[i] <= '0;
            end
            qa_q  <= '0;
            qb_q  <= '0;
            out_q <= '0;
        end else begin
            for (int unsigned i = 1; i < 4; i++) begin
                r_q[i] <= r_d[i];
            end
            qa_q  <= qa_d;
            qb_q  <= qb_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef CALC_DATAPATH_FLAGS_EN
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic [W:0]   sum_ext;

    // Flags track only ALU results that are actually committed to a real register.
    always_comb begin
        sum_ext = {1'b0, qa_q} + {1'b0, qb_q};
        carry_d = carry_q;
        zero_d  = zero_q;
        if (wr_en && (sel_e'(s1) == SEL_ALU)) begin
            case (op_e'(C))
                OP_ADD:  carry_d = sum_ext[W];
                OP_SUB:  carry_d = (qa_q < qb_q);
                default: carry_d = 1'b0;
            endcase
            zero_d = (alu == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`else
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

endmodule

// File: tb/tb_calc_datapath.sv
// Scoreboarded bench for calc_datapath: directed sequences plus randomized operand/op runs.
module tb_calc_datapath;

    localparam int W = 4;
    localparam int MOD = 1 << W;
`ifdef CALC_DATAPATH_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic [1:0]   s1 = '0, WA = '0, RAA = '0, RAB = '0, C = '0;
    logic         WE = 1'b0, REA = 1'b0, REB = 1'b0, S2 = 1'b0;
    logic [W-1:0] out;
    logic         carry, zero;

    calc_datapath #(.W(W)) dut (
        .clk(clk), .rst(rst), .in1(in1), .in2(in2), .s1(s1), .WA(WA), .WE(WE),
        .RAA(RAA), .RAB(RAB), .REA(REA), .REB(REB), .C(C), .S2(S2),
        .out(out), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic         c;
        logic         z;
        int           tag;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   tag_cnt = 0;

    task automatic chk(input string nm, input int tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (item %0d): got %0h, expected %0h", nm, tag, act, exp);
        end
    endtask

    task automatic push(input int o, input bit c, input bit z);
        exp_t e;
        e.o   = W'(o);
        e.c   = FLAGS ? c : 1'b0;
        e.z   = FLAGS ? z : 1'b0;
        e.tag = tag_cnt++;
        sbq.push_back(e);
    endtask

    // Monitor: every accepted output-load strobe produces one observation to score.
    logic s2_seen = 1'b0;
    always @(posedge clk) s2_seen <= S2 & ~rst;

    always @(negedge clk) begin
        if (s2_seen) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_load: out=%0h with no expected entry", out);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out",   e.tag, out,          e.o);
                chk("carry", e.tag, W'(carry),    W'(e.c));
                chk("zero",  e.tag, W'(zero),     W'(e.z));
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] wa, input logic [1:0] sel,
                         input logic [W-1:0] i1, input logic [W-1:0] i2,
                         input logic rea, input logic [1:0] raa,
                         input logic reb, input logic [1:0] rab,
                         input logic [1:0] op, input logic s2, input logic r);
        WE = we; WA = wa; s1 = sel; in1 = i1; in2 = i2;
        REA = rea; RAA = raa; REB = reb; RAB = rab; C = op; S2 = s2; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 2'd0, W'($urandom), W'($urandom), 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    endtask

    // Reference: result and flags straight from the arithmetic definitions.
    task automatic model(input int a, input int b, input int op, output int res, output bit c, output bit z);
        case (op)
            3: begin res = (a + b) % MOD;       c = (a + b) >= MOD; end
            2: begin res = (a - b + MOD) % MOD; c = a < b;          end
            1: begin res = a & b;               c = 1'b0;           end
            default: begin res = a ^ b;         c = 1'b0;           end
        endcase
        z = (res == 0);
    endtask

    // Full sequence: write A, write B, read both, ALU-write R3, then load out (or fused load).
    task automatic run_op(input int a, input int b, input int op, input int ra, input int rb,
                          input bit fuse, input bit rnd);
        int res; bit c, z;
        logic [1:0] ws;
        model(a, b, op, res, c, z);
        drive(1'b1, 2'(ra), 2'd3, W'(a), W'($urandom), rnd & 1'($urandom), 2'($urandom),
              rnd & 1'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b0);
        drive(1'b1, 2'(rb), 2'd2, W'($urandom), W'(b), rnd & 1'($urandom), 2'($urandom),
              rnd & 1'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b0);
        ws = rnd ? 2'($urandom) : 2'd0;
        drive(rnd & 1'($urandom), 2'd0, ws, W'($urandom), W'($urandom), 1'b1, 2'(ra),
              1'b1, 2'(rb), 2'($urandom), 1'b0, 1'b0);
        if (fuse) push(res, c, z);
        drive(1'b1, 2'd3, 2'd0, W'($urandom), W'($urandom), rnd & 1'($urandom), 2'($urandom),
              rnd & 1'($urandom), 2'($urandom), 2'(op), fuse, 1'b0);
        if (!fuse) begin
            push(res, c, z);
            drive(1'b0, 2'd0, 2'd0, W'($urandom), W'($urandom), rnd & 1'($urandom), 2'($urandom),
                  rnd & 1'($urandom), 2'($urandom), 2'($urandom), 1'b1, 1'b0);
        end
    endtask

    initial begin
        repeat (2) drive(1'b1, 2'd3, 2'd3, 4'hF, 4'hF, 1'b1, 2'd3, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1);
        idle();
        chk("reset_out",   -1, out,       '0);
        chk("reset_carry", -1, W'(carry), '0);
        chk("reset_zero",  -1, W'(zero),  '0);

        run_op(5, 3, 3, 1, 2, 1'b0, 1'b0);
        run_op(3, 5, 2, 1, 2, 1'b0, 1'b0);
        run_op(9, 9, 3, 1, 2, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 2'd3, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        chk("hold_out",   -1, out,       4'h2);
        chk("hold_carry", -1, W'(carry), W'(FLAGS));
        run_op(12, 10, 1, 1, 2, 1'b0, 1'b0);
        run_op(12, 10, 0, 1, 2, 1'b0, 1'b0);
        run_op(7, 7, 2, 1, 2, 1'b0, 1'b0);

        // R0 must stay zero after an attempted write.
        drive(1'b1, 2'd0, 2'd3, 4'hF, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        push(0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

        // Write-first bypass: R1 holds 9, same-cycle write of 6 must be what QA sees.
        drive(1'b1, 2'd1, 2'd3, 4'h9, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 2'd3, 4'h6, 4'h0, 1'b1, 2'd1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        push(6, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

        // Reset during the ALU-write cycle of 5+3.
        drive(1'b1, 2'd1, 2'd3, 4'h5, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 2'd2, 4'h0, 4'h3, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1, 2'd1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 2'd0, 4'h0, 4'h0, 1'b1, 2'd3, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1);
        chk("rst_mid_out",   -1, out,       '0);
        chk("rst_mid_carry", -1, W'(carry), '0);
        chk("rst_mid_zero",  -1, W'(zero),  '0);
        push(0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1, 2'd1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b0);
        push(0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 2'd0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int ra, rb;
            ra = $urandom_range(1, 3);
            rb = $urandom_range(1, 2);
            if (rb >= ra) rb = rb + 1;
            run_op($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), $urandom_range(0, 3),
                   ra, rb, 1'($urandom), 1'b1);
        end

        repeat (3) idle();
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pending: %0d expected loads never observed, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
